// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, ALU op codes, instruction field positions and FSM states
package alu_pkg;
  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int AW     = 3;
  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_NOT = 3'd4;
  localparam logic [2:0] ALU_EQ  = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;
  localparam int OP_LSB  = 13;
  localparam int RD_LSB  = 10;
  localparam int RS1_LSB = 7;
  localparam int RS2_LSB = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction, host-write, ALU and result signals of the issue sequencer
interface alu_issue_ctrl_if;
  import alu_pkg::*;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic              host_we;
  logic [AW-1:0]     host_addr;
  logic [DATA_W-1:0] host_data;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zero;
  logic              done;
  logic [DATA_W-1:0] res_data;
  logic [AW-1:0]     res_rd;
  logic              zero_flag;
  modport slave (
    input  instr_valid, instr, host_we, host_addr, host_data, alu_out, alu_zero,
    output instr_ready, alu_a, alu_b, alu_ctrl, done, res_data, res_rd, zero_flag
  );
  modport master (
    output instr_valid, instr, host_we, host_addr, host_data, alu_out, alu_zero,
    input  instr_ready, alu_a, alu_b, alu_ctrl, done, res_data, res_rd, zero_flag
  );
endinterface

// File: rtl/alu_regfile.sv
// alu_regfile: 8x16 register file, two async read ports, one sync write port
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  logic [DATA_W-1:0] mem [NREGS];
  always_ff @(posedge clk)
    if (rst) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: IDLE/ISSUE/WB sequencer feeding the ALU from a register file and writing results back
module alu_issue_ctrl
  import alu_pkg::*;
(
  input logic clk,
  input logic rst,
  alu_issue_ctrl_if.slave bus
);
  state_t            state;
  logic [2:0]        op_q;
  logic [AW-1:0]     rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0] res_q;
  logic              zq, zf, ready_q, done_q;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [3:0]        unused_rsvd;
  assign unused_rsvd = bus.instr[3:0];
  // WB owns the write port; host writes only land while idle
  always_comb begin
    rf_we    = (state == WB) || (state == IDLE && bus.host_we);
    rf_waddr = (state == WB) ? rd_q : bus.host_addr;
    rf_wdata = (state == WB) ? res_q : bus.host_data;
  end
  alu_regfile u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .ra1   (rs1_q),
    .ra2   (rs2_q),
    .rd1   (bus.alu_a),
    .rd2   (bus.alu_b)
  );
  assign bus.alu_ctrl    = op_q;
  assign bus.instr_ready = ready_q;
  assign bus.done        = done_q;
  assign bus.res_data    = res_q;
  assign bus.res_rd      = rd_q;
  assign bus.zero_flag   = zf;
  always_ff @(posedge clk)
    if (rst) begin
      state   <= IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      res_q   <= '0;
      zq      <= 1'b0;
      zf      <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else
      case (state)
        IDLE:
          if (bus.instr_valid) begin
            op_q    <= bus.instr[OP_LSB +: 3];
            rd_q    <= bus.instr[RD_LSB +: AW];
            rs1_q   <= bus.instr[RS1_LSB +: AW];
            rs2_q   <= bus.instr[RS2_LSB +: AW];
            ready_q <= 1'b0;
            state   <= ISSUE;
          end
        ISSUE: begin
          res_q  <= bus.alu_out;
          zq     <= bus.alu_zero;
          done_q <= 1'b1;
          state  <= WB;
        end
        WB: begin
          zf      <= zq;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: table-driven and directed checks of the issue sequencer against a behavioural ALU
module tb_alu_issue_ctrl;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  always #5 clk = ~clk;
  alu_issue_ctrl_if bus ();
  alu_issue_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  // behavioural ALU: shifts are by one bit, EQ yields 1/0
  always_comb begin
    case (bus.alu_ctrl)
      ALU_AND: bus.alu_out = bus.alu_a & bus.alu_b;
      ALU_OR:  bus.alu_out = bus.alu_a | bus.alu_b;
      ALU_ADD: bus.alu_out = bus.alu_a + bus.alu_b;
      ALU_SUB: bus.alu_out = bus.alu_a - bus.alu_b;
      ALU_NOT: bus.alu_out = ~bus.alu_a;
      ALU_EQ:  bus.alu_out = {15'd0, bus.alu_a == bus.alu_b};
      ALU_SHL: bus.alu_out = bus.alu_a << 1;
      default: bus.alu_out = bus.alu_a >> 1;
    endcase
    bus.alu_zero = (bus.alu_out == 16'd0);
  end
  typedef struct {
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] res;
    logic        z;
  } vec_t;
  vec_t vt [11];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  function automatic logic [15:0] enc(input logic [2:0] op, rd, rs1, rs2);
    return {op, rd, rs1, rs2, 4'($urandom)};
  endfunction
  task automatic host_wr(input logic [2:0] a, input logic [15:0] d);
    bus.host_we = 1'b1; bus.host_addr = a; bus.host_data = d;
    @(negedge clk);
    bus.host_we = 1'b0;
  endtask
  task automatic wait_ready(input string nm);
    int n = 0;
    while (!bus.instr_ready && n < 10) begin @(negedge clk); n++; end
    chk({nm, "_ready_timeout"}, 32'(n < 10), 32'd1);
  endtask
  task automatic exec(input string nm, input logic [2:0] op, rd, rs1, rs2,
                      input logic [15:0] res, input logic z);
    wait_ready(nm);
    bus.instr_valid = 1'b1;
    bus.instr = enc(op, rd, rs1, rs2);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk({nm, "_done_issue"}, 32'(bus.done), 32'd0);
    @(negedge clk);
    chk({nm, "_done"}, 32'(bus.done), 32'd1);
    chk({nm, "_res"}, 32'(bus.res_data), 32'(res));
    chk({nm, "_rd"}, 32'(bus.res_rd), 32'(rd));
    @(negedge clk);
    chk({nm, "_zero"}, 32'(bus.zero_flag), 32'(z));
    chk({nm, "_ready_after"}, 32'(bus.instr_ready), 32'd1);
  endtask
  initial begin
    logic [15:0] r [3];
    int acc [3];
    int idx, nd;
    logic [2:0] sq [3][4];
    bus.instr_valid = 1'b0; bus.instr = '0;
    bus.host_we = 1'b0; bus.host_addr = '0; bus.host_data = '0;
    vt[0]  = '{ALU_ADD, 3'd3, 3'd1, 3'd2, 16'h0008, 1'b0};
    vt[1]  = '{ALU_OR,  3'd4, 3'd3, 3'd0, 16'h0008, 1'b0};
    vt[2]  = '{ALU_SUB, 3'd4, 3'd1, 3'd1, 16'h0000, 1'b1};
    vt[3]  = '{ALU_ADD, 3'd7, 3'd5, 3'd6, 16'h0000, 1'b1};
    vt[4]  = '{ALU_EQ,  3'd0, 3'd1, 3'd1, 16'h0001, 1'b0};
    vt[5]  = '{ALU_AND, 3'd3, 3'd3, 3'd2, 16'h0000, 1'b1};
    vt[6]  = '{ALU_SHL, 3'd4, 3'd2, 3'd0, 16'h0006, 1'b0};
    vt[7]  = '{ALU_SHR, 3'd4, 3'd5, 3'd0, 16'h7FFF, 1'b0};
    vt[8]  = '{ALU_NOT, 3'd4, 3'd1, 3'd0, 16'hFFFA, 1'b0};
    vt[9]  = '{ALU_SUB, 3'd4, 3'd2, 3'd1, 16'hFFFE, 1'b0};
    vt[10] = '{ALU_EQ,  3'd4, 3'd1, 3'd2, 16'h0000, 1'b1};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_zero", 32'(bus.zero_flag), 32'd0);
    chk("rst_res", 32'(bus.res_data), 32'd0);
    chk("rst_res_rd", 32'(bus.res_rd), 32'd0);
    chk("rst_alu", {bus.alu_a, bus.alu_b}, 32'd0);
    chk("rst_ctrl", 32'(bus.alu_ctrl), 32'd0);
    for (int i = 0; i < 8; i++) exec($sformatf("rst_rf%0d", i), ALU_OR, 3'(i), 3'(i), 3'(i), 16'h0000, 1'b1);
    host_wr(3'd1, 16'h0005);
    host_wr(3'd2, 16'h0003);
    host_wr(3'd5, 16'hFFFF);
    host_wr(3'd6, 16'h0001);
    for (int i = 0; i < 11; i++)
      exec($sformatf("vec%0d", i), vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].res, vt[i].z);
    // back-to-back with instr_valid held high
    host_wr(3'd1, 16'h0005);
    sq[0] = '{ALU_ADD, 3'd1, 3'd1, 3'd1};
    sq[1] = '{ALU_ADD, 3'd1, 3'd1, 3'd1};
    sq[2] = '{ALU_OR,  3'd2, 3'd1, 3'd1};
    idx = 0; nd = 0;
    bus.instr_valid = 1'b1;
    bus.instr = enc(sq[0][0], sq[0][1], sq[0][2], sq[0][3]);
    for (int c = 0; c < 14; c++) begin
      if (bus.done && nd < 3) begin r[nd] = bus.res_data; nd++; end
      if (bus.instr_valid && bus.instr_ready && idx < 3) begin acc[idx] = c; idx++; end
      @(negedge clk);
      bus.instr_valid = (idx < 3);
      if (idx < 3) bus.instr = enc(sq[idx][0], sq[idx][1], sq[idx][2], sq[idx][3]);
    end
    chk("b2b_accepts", 32'(idx), 32'd3);
    chk("b2b_dones", 32'(nd), 32'd3);
    chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd3);
    chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd3);
    chk("b2b_res0", 32'(r[0]), 32'h000A);
    chk("b2b_res1", 32'(r[1]), 32'h0014);
    chk("b2b_res2", 32'(r[2]), 32'h0014);
    // host writes during ISSUE and WB must be dropped
    host_wr(3'd5, 16'h00AA);
    host_wr(3'd6, 16'h0055);
    wait_ready("drop");
    bus.instr_valid = 1'b1; bus.instr = enc(ALU_ADD, 3'd3, 3'd1, 3'd1);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.host_we = 1'b1; bus.host_addr = 3'd5; bus.host_data = 16'h1234;
    @(negedge clk);
    bus.host_addr = 3'd6; bus.host_data = 16'h5678;
    chk("drop_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    bus.host_we = 1'b0;
    exec("drop_r5", ALU_OR, 3'd7, 3'd5, 3'd5, 16'h00AA, 1'b0);
    exec("drop_r6", ALU_OR, 3'd7, 3'd6, 3'd6, 16'h0055, 1'b0);
    // host write and accept in the same cycle
    bus.host_we = 1'b1; bus.host_addr = 3'd2; bus.host_data = 16'h00F0;
    bus.instr_valid = 1'b1; bus.instr = enc(ALU_NOT, 3'd3, 3'd2, 3'd0);
    @(negedge clk);
    bus.host_we = 1'b0; bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("same_done", 32'(bus.done), 32'd1);
    chk("same_res", 32'(bus.res_data), 32'hFF0F);
    @(negedge clk);
    // reset during ISSUE
    exec("pre_rst_sub", ALU_SUB, 3'd4, 3'd1, 3'd1, 16'h0000, 1'b1);
    bus.instr_valid = 1'b1; bus.instr = enc(ALU_ADD, 3'd3, 3'd1, 3'd1);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", 32'(bus.instr_ready), 32'd1);
    chk("mid_rst_zero", 32'(bus.zero_flag), 32'd0);
    chk("mid_rst_res", 32'(bus.res_data), 32'd0);
    nd = 0;
    for (int c = 0; c < 3; c++) begin
      if (bus.done) nd++;
      @(negedge clk);
    end
    chk("mid_rst_no_done", 32'(nd), 32'd0);
    for (int i = 0; i < 8; i++) exec($sformatf("mid_rst_rf%0d", i), ALU_OR, 3'(i), 3'(i), 3'(i), 16'h0000, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
